// File: rtl/forwarding_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for a 5-stage pipeline.
// Optional saturating stall counter enabled by defining FWD_STALL_CNT_EN.
module forwarding_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int CNT_W     = 16,
  localparam int SELW     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_use_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_memread_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      flush_i,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
  output logic                      stall_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  typedef enum logic {RUN, STALL} state_e;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [REG_AW-1:0] rd;
  } stage_t;

  state_e state_q, state_d;

  logic                      ex_valid_q, ex_valid_d;
  logic [NUM_SRC*REG_AW-1:0] ex_src_q;
  logic [NUM_SRC-1:0]        ex_use_q;
  logic                      ex_regwrite_q;
  logic                      ex_memread_q;
  logic [REG_AW-1:0]         ex_rd_q;

  // Index 0 is EX/MEM (stage 1); index FWD_DEPTH-1 is the oldest stage.
  stage_t s_q [FWD_DEPTH];
  stage_t s_d [FWD_DEPTH];

  logic ex_is_load;
  logic rs_match;
  logic hazard;

  function automatic logic is_writer(input stage_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

  // Load-use hazard: a load in EX whose result an operand in ID needs.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    rs_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_use_i[i] && (id_rs_i[i*REG_AW +: REG_AW] == ex_rd_q)) rs_match = 1'b1;
    end
    ex_is_load = ex_valid_q && ex_memread_q && ex_regwrite_q && (ex_rd_q != '0);
    hazard     = ex_is_load && id_valid_i && rs_match;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      RUN: begin
        stall_o = hazard && !flush_i;
        if (stall_o) state_d = STALL;
      end
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Scan oldest to nearest so the nearest matching stage overrides.
  always_comb begin
    fwd_sel_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (ex_valid_q && ex_use_q[i] && is_writer(s_q[k]) &&
            (s_q[k].rd == ex_src_q[i*REG_AW +: REG_AW]))
          fwd_sel_o[i*SELW +: SELW] = SELW'(k + 1);
      end
    end
  end

  always_comb begin
    ex_valid_d = id_valid_i && !stall_o && !flush_i;
    s_d[0]     = '{valid: ex_valid_q, regwrite: ex_regwrite_q, rd: ex_rd_q};
    for (int k = 1; k < FWD_DEPTH; k++) s_d[k] = s_q[k-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q       <= RUN;
      ex_valid_q    <= 1'b0;
      ex_src_q      <= '0;
      ex_use_q      <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_rd_q       <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) s_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      ex_valid_q    <= ex_valid_d;
      ex_src_q      <= id_rs_i;
      ex_use_q      <= id_rs_use_i;
      ex_regwrite_q <= id_regwrite_i;
      ex_memread_q  <= id_memread_i;
      ex_rd_q       <= id_rd_i;
      for (int k = 0; k < FWD_DEPTH; k++) s_q[k] <= s_d[k];
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// Directed-vector bench for forwarding_hazard_ctrl (REG_AW=5, NUM_SRC=2, FWD_DEPTH=2, CNT_W=2).
module tb_forwarding_hazard_ctrl;

`ifdef FWD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [9:0] id_rs_i;
  logic [1:0] id_rs_use_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic [4:0] id_rd_i;
  logic       flush_i;
  logic [3:0] fwd_sel_o;
  logic       stall_o;
  logic [1:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  forwarding_hazard_ctrl #(
    .REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .CNT_W(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
    .id_rs_use_i(id_rs_use_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .id_rd_i(id_rd_i), .flush_i(flush_i),
    .fwd_sel_o(fwd_sel_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] use_v, input logic rw, input logic mr,
                        input logic [4:0] rd);
    id_valid_i    = v;
    id_rs_i       = {rs1, rs0};
    id_rs_use_i   = use_v;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    id_rd_i       = rd;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic drain();
    idle();
    flush_i = 1'b0;
    repeat (3) cyc();
  endtask

  function automatic logic [1:0] exp_cnt(input int n);
    return CNT_EN ? 2'(n) : 2'd0;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; idle();
    repeat (2) cyc();
    rst_i = 1'b0;
    #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0000 || stall_o !== 1'b0 || stall_cnt_o !== 2'd0) begin
      n_err++;
      $display("FAIL reset: sel=%b stall=%b cnt=%0d, want sel=0000 stall=0 cnt=0",
               fwd_sel_o, stall_o, stall_cnt_o);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 5'd4, 5'd5, 2'b11, 1'b1, 1'b0, 5'd1); cyc();  // add r1,r4,r5
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0, 5'd3); #1;     // add r3,r1,r2
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_nostall: stall=%b want 0", stall_o);
    end
    cyc(); idle(); #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0001) begin
      n_err++; $display("FAIL b2b_sel: sel=%b want 0001", fwd_sel_o);
    end
    drain();
  endtask

  task automatic test_priority();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 5'd1); cyc();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 5'd1); cyc();
    set_id(1'b1, 5'd1, 5'd7, 2'b01, 1'b0, 1'b0, 5'd0); cyc();
    idle(); #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0001) begin
      n_err++; $display("FAIL prio_near: sel=%b want 0001", fwd_sel_o);
    end
    drain();
    // Nearer write targets r0, so the older r1 write at stage 2 wins; operand 1 consumes.
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 5'd1); cyc();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 5'd0); cyc();
    set_id(1'b1, 5'd7, 5'd1, 2'b10, 1'b0, 1'b0, 5'd0); cyc();
    idle(); #1;
    n_vec++;
    if (fwd_sel_o !== 4'b1000) begin
      n_err++; $display("FAIL prio_r0: sel=%b want 1000", fwd_sel_o);
    end
    drain();
  endtask

  task automatic test_load_use(input logic [1:0] cnt_want);
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd2); cyc();  // lw r2
    set_id(1'b1, 5'd2, 5'd3, 2'b11, 1'b1, 1'b0, 5'd4); #1;     // add r4,r2,r3
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++; $display("FAIL lu_stall: stall=%b want 1", stall_o);
    end
    cyc(); #1;  // consumer held in ID
    n_vec++;
    if (stall_o !== 1'b0 || fwd_sel_o !== 4'b0000) begin
      n_err++; $display("FAIL lu_bubble: stall=%b sel=%b want 0 0000", stall_o, fwd_sel_o);
    end
    n_vec++;
    if (stall_cnt_o !== cnt_want) begin
      n_err++; $display("FAIL lu_cnt: cnt=%0d want %0d", stall_cnt_o, cnt_want);
    end
    cyc(); idle(); #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0010 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL lu_fwd: sel=%b stall=%b want 0010 0", fwd_sel_o, stall_o);
    end
    drain();
  endtask

  task automatic test_no_false_stall();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd2); cyc();  // lw r2
    set_id(1'b1, 5'd5, 5'd2, 2'b01, 1'b1, 1'b0, 5'd6); #1;     // rs1=r2 but unused
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL nfs_unused: stall=%b want 0", stall_o);
    end
    cyc(); idle(); #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0000) begin
      n_err++; $display("FAIL nfs_unused_sel: sel=%b want 0000", fwd_sel_o);
    end
    drain();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd0); cyc();  // lw r0
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0, 5'd6); #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL nfs_r0: stall=%b want 0", stall_o);
    end
    cyc(); idle(); #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0000) begin
      n_err++; $display("FAIL nfs_r0_sel: sel=%b want 0000", fwd_sel_o);
    end
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd2); cyc();  // lw r2
    set_id(1'b1, 5'd2, 5'd2, 2'b11, 1'b1, 1'b0, 5'd4); flush_i = 1'b1; #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL flush_stall: stall=%b want 0", stall_o);
    end
    cyc(); idle(); flush_i = 1'b0; #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0000 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL flush_bubble: sel=%b stall=%b want 0000 0", fwd_sel_o, stall_o);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd2); cyc();
    set_id(1'b1, 5'd2, 5'd0, 2'b01, 1'b1, 1'b0, 5'd4); #1;
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_stall: stall=%b want 1", stall_o);
    end
    cyc();
    rst_i = 1'b1; cyc();
    rst_i = 1'b0; #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0000 || stall_o !== 1'b0 || stall_cnt_o !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid_stall: sel=%b stall=%b cnt=%0d want 0000 0 0",
               fwd_sel_o, stall_o, stall_cnt_o);
    end
    cyc(); idle(); #1;
    n_vec++;
    if (fwd_sel_o !== 4'b0000) begin
      n_err++; $display("FAIL rst_entries: sel=%b want 0000", fwd_sel_o);
    end
    drain();
  endtask

  task automatic test_cnt_saturation();
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    for (int p = 0; p < 5; p++) begin
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd2); cyc();
      set_id(1'b1, 5'd0, 5'd2, 2'b10, 1'b1, 1'b0, 5'd9); #1;
      n_vec++;
      if (stall_o !== 1'b1) begin
        n_err++; $display("FAIL sat_stall%0d: stall=%b want 1", p, stall_o);
      end
      cyc(); cyc();
    end
    idle(); #1;
    n_vec++;
    if (stall_cnt_o !== exp_cnt(3)) begin
      n_err++; $display("FAIL sat_cnt: cnt=%0d want %0d", stall_cnt_o, exp_cnt(3));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_priority();
    test_load_use(exp_cnt(1));
    test_no_false_stall();
    test_flush();
    test_reset_mid_stall();
    test_cnt_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
